// File: rtl/score_pkg.sv
// Shared constants, glyph bitmaps and FSM encoding for the score renderer.
package score_pkg;

   localparam int GLYPH_W = 13;

   localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 13'b0000000000000;

   localparam logic [GLYPH_W-1:0] GLYPH_TABLE [0:9] = '{
      13'b1111110111111,
      13'b0010100101001,
      13'b1110111110111,
      13'b1110111101111,
      13'b1011111101001,
      13'b1111011101111,
      13'b1111011111111,
      13'b1110100101001,
      13'b1111111111111,
      13'b1111111101111
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_LOOKUP = 2'd2
   } state_t;

   // Largest value representable in the given number of decimal digits.
   function automatic int unsigned max_score(input int unsigned digits);
      int unsigned p;
      p = 32'd1;
      for (int unsigned i = 32'd0; i < digits; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/score_display_glyph_rom.sv
// Combinational BCD digit to 13-bit glyph lookup; non-decimal codes render blank.
module glyph_rom
   import score_pkg::*;
(
   input  logic [3:0]         digit,
   output logic [GLYPH_W-1:0] glyph
);

   // Table lookup with blank fallback for codes 10..15
   always_comb begin
      case (digit)
         4'd0:    glyph = GLYPH_TABLE[0];
         4'd1:    glyph = GLYPH_TABLE[1];
         4'd2:    glyph = GLYPH_TABLE[2];
         4'd3:    glyph = GLYPH_TABLE[3];
         4'd4:    glyph = GLYPH_TABLE[4];
         4'd5:    glyph = GLYPH_TABLE[5];
         4'd6:    glyph = GLYPH_TABLE[6];
         4'd7:    glyph = GLYPH_TABLE[7];
         4'd8:    glyph = GLYPH_TABLE[8];
         4'd9:    glyph = GLYPH_TABLE[9];
         default: glyph = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display.sv
// Binary score to multi-digit glyph renderer: saturating capture, sequential
// double-dabble BCD conversion, then one lookup cycle with leading-zero blanking.
module score_display
   import score_pkg::*;
#(
   parameter int SCORE_W  = 10,
   parameter int DIGITS   = 3,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SCORE_W-1:0]        score,
   input  logic                      load,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
   output logic [DIGITS*GLYPH_W-1:0] glyphs
);

   if (DIGITS < 1 || DIGITS > 6 || SCORE_W < 1 || SCORE_W > 20) begin : g_param_check
      $fatal(1, "score_display: DIGITS must be 1..6 and SCORE_W must be 1..20");
   end

   localparam int            BCD_W     = 4 * DIGITS;
   localparam int unsigned   MAX_SCORE = max_score(DIGITS);
   localparam logic [31:0]   MAX_V     = 32'(MAX_SCORE);
   localparam logic [SCORE_W-1:0] MAX_BIN = MAX_V[SCORE_W-1:0];
   localparam logic [4:0]    ITER_LOAD = 5'(SCORE_W);

   function automatic logic [DIGITS*GLYPH_W-1:0] reset_glyphs();
      logic [DIGITS*GLYPH_W-1:0] r;
      r = {(DIGITS*GLYPH_W){1'b0}};
      for (int d = 0; d < DIGITS; d++) begin
         if (d == 0 || !BLANK_LZ) begin
            r[d*GLYPH_W +: GLYPH_W] = GLYPH_TABLE[0];
         end else begin
            r[d*GLYPH_W +: GLYPH_W] = GLYPH_BLANK;
         end
      end
      return r;
   endfunction

   localparam logic [DIGITS*GLYPH_W-1:0] RST_GLYPHS = reset_glyphs();

   state_t                    state_r, state_s;
   logic [SCORE_W-1:0]        bin_r, bin_s;
   logic [BCD_W-1:0]          bcd_r, bcd_s;
   logic [4:0]                cnt_r, cnt_s;
   logic                      pend_ovf_r, pend_ovf_s;
   logic [DIGITS*GLYPH_W-1:0] glyphs_r, glyphs_s;
   logic                      overflow_r, overflow_s;
   logic                      done_r, done_s;
   logic                      busy_r, busy_s;

   logic [31:0]               score_ext_s;
   logic [BCD_W-1:0]          adj_bcd_s;
   logic [BCD_W-1:0]          shift_bcd_s;
   logic [SCORE_W-1:0]        shift_bin_s;
   logic [GLYPH_W-1:0]        rom_glyph_s [DIGITS];
   logic [DIGITS*GLYPH_W-1:0] lookup_s;

   assign score_ext_s = {{(32-SCORE_W){1'b0}}, score};

   for (genvar d = 0; d < DIGITS; d++) begin : g_rom
      glyph_rom u_rom (
         .digit (bcd_r[d*4 +: 4]),
         .glyph (rom_glyph_s[d])
      );
   end

   // One double-dabble iteration: add-3 correction, then shift {bcd, bin} left
   always_comb begin
      adj_bcd_s = bcd_r;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_r[d*4 +: 4] >= 4'd5) begin
            adj_bcd_s[d*4 +: 4] = bcd_r[d*4 +: 4] + 4'd3;
         end else begin
            adj_bcd_s[d*4 +: 4] = bcd_r[d*4 +: 4];
         end
      end
      shift_bcd_s = {adj_bcd_s[BCD_W-2:0], bin_r[SCORE_W-1]};
      shift_bin_s = bin_r << 1;
   end

   // Glyph selection with leading-zero blanking scanned from the top digit down
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lookup_s   = {(DIGITS*GLYPH_W){1'b0}};
      for (int d = DIGITS - 1; d >= 0; d--) begin
         if (bcd_r[d*4 +: 4] != 4'd0) begin
            zero_above = 1'b0;
         end else begin
            zero_above = zero_above;
         end
         if (BLANK_LZ && d > 0 && zero_above) begin
            lookup_s[d*GLYPH_W +: GLYPH_W] = GLYPH_BLANK;
         end else begin
            lookup_s[d*GLYPH_W +: GLYPH_W] = rom_glyph_s[d];
         end
      end
   end

   // FSM next-state and datapath control
   always_comb begin
      state_s    = state_r;
      bin_s      = bin_r;
      bcd_s      = bcd_r;
      cnt_s      = cnt_r;
      pend_ovf_s = pend_ovf_r;
      glyphs_s   = glyphs_r;
      overflow_s = overflow_r;
      done_s     = 1'b0;
      busy_s     = busy_r;
      case (state_r)
         ST_IDLE: begin
            if (load) begin
               if (score_ext_s > MAX_V) begin
                  bin_s      = MAX_BIN;
                  pend_ovf_s = 1'b1;
               end else begin
                  bin_s      = score;
                  pend_ovf_s = 1'b0;
               end
               bcd_s   = {BCD_W{1'b0}};
               cnt_s   = ITER_LOAD;
               busy_s  = 1'b1;
               state_s = ST_SHIFT;
            end else begin
               busy_s  = 1'b0;
            end
         end
         ST_SHIFT: begin
            bin_s  = shift_bin_s;
            bcd_s  = shift_bcd_s;
            cnt_s  = cnt_r - 5'd1;
            busy_s = 1'b1;
            if (cnt_r == 5'd1) begin
               state_s = ST_LOOKUP;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_LOOKUP: begin
            glyphs_s   = lookup_s;
            overflow_s = pend_ovf_r;
            done_s     = 1'b1;
            busy_s     = 1'b1;
            state_s    = ST_IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         bin_r      <= {SCORE_W{1'b0}};
         bcd_r      <= {BCD_W{1'b0}};
         cnt_r      <= 5'd0;
         pend_ovf_r <= 1'b0;
         glyphs_r   <= RST_GLYPHS;
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         bin_r      <= bin_s;
         bcd_r      <= bcd_s;
         cnt_r      <= cnt_s;
         pend_ovf_r <= pend_ovf_s;
         glyphs_r   <= glyphs_s;
         overflow_r <= overflow_s;
         done_r     <= done_s;
         busy_r     <= busy_s;
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign overflow = overflow_r;
   assign glyphs   = glyphs_r;

endmodule
